// File: rtl/i2cmb_chk_pkg.sv
// i2cmb_chk_pkg: register offsets, CSR bit positions and error-vector layout for the protocol checker
package i2cmb_chk_pkg;
    typedef enum logic [1:0] {
        REG_CSR  = 2'd0,
        REG_DPR  = 2'd1,
        REG_CMDR = 2'd2,
        REG_FSMR = 2'd3
    } reg_off_e;

    localparam int CSR_E  = 7;
    localparam int CSR_IE = 6;
    localparam int CSR_BB = 5;
    localparam int CSR_BC = 4;

    localparam int ERR_WB     = 0;
    localparam int ERR_STABLE = 1;
    localparam int ERR_REG    = 2;
    localparam int ERR_IRQ    = 3;
    localparam int ERR_W      = 4;
endpackage

// File: rtl/i2cmb_protocol_checker_i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes one I2C bus, tracks busy between START/STOP and flags STOP while idle
module i2c_bus_monitor
    import i2cmb_chk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic busy,
    output logic err,
    output logic viol
);
    logic [1:0] scl_s, sda_s;
    logic scl_q, sda_q, start, stop;

    // scl must be high in both samples, so a simultaneous scl/sda change never counts
    always_comb begin
        start = scl_s[1] && scl_q && sda_q && !sda_s[1];
        stop  = scl_s[1] && scl_q && !sda_q && sda_s[1];
        viol  = stop && !busy;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            scl_s <= {scl_s[0], scl};
            sda_s <= {sda_s[0], sda};
            scl_q <= scl_s[1];
            sda_q <= sda_s[1];
            busy  <= start || (busy && !stop);
            err   <= err || viol;
        end
    end
endmodule

// File: rtl/i2cmb_protocol_checker.sv
// i2cmb_protocol_checker: passive monitor of the I2C multi-bus controller's Wishbone port, irq and I2C busses
module i2cmb_protocol_checker
    import i2cmb_chk_pkg::*;
#(
    parameter int NUM_I2C_BUSSES = 1,
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      irq_i,
    input  logic                      cyc_o,
    input  logic                      stb_o,
    input  logic                      we_o,
    input  logic                      ack_i,
    input  logic [WB_ADDR_WIDTH-1:0]  adr_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic [NUM_I2C_BUSSES-1:0] scl_i,
    input  logic [NUM_I2C_BUSSES-1:0] sda_i,
    output logic                      err_wb,
    output logic                      err_stable,
    output logic                      err_reg,
    output logic                      err_irq,
    output logic [NUM_I2C_BUSSES-1:0] err_i2c,
    output logic                      err_any,
    output logic [15:0]               err_count,
    output logic [NUM_I2C_BUSSES-1:0] i2c_busy
);
    logic [ERR_W-1:0] flags, viol;
    logic [NUM_I2C_BUSSES-1:0] i2c_viol;
    logic [WB_ADDR_WIDTH-1:0] adr_q;
    logic [WB_DATA_WIDTH-1:0] dat_q, csr_rsvd;
    logic ack_q, stb_q, wait_q, we_q, ie_q, cmdr_rd_q;
    logic acc, is_csr, is_cmdr, is_fsmr;

    for (genvar b = 0; b < NUM_I2C_BUSSES; b++) begin : g_bus
        i2c_bus_monitor u_mon (
            .clk  (clk),
            .rst  (rst),
            .scl  (scl_i[b]),
            .sda  (sda_i[b]),
            .busy (i2c_busy[b]),
            .err  (err_i2c[b]),
            .viol (i2c_viol[b])
        );
    end

    always_comb begin
        acc      = cyc_o && stb_o && ack_i;
        is_csr   = adr_o == WB_ADDR_WIDTH'(REG_CSR);
        is_cmdr  = adr_o == WB_ADDR_WIDTH'(REG_CMDR);
        is_fsmr  = adr_o == WB_ADDR_WIDTH'(REG_FSMR);
        csr_rsvd = dat_i & WB_DATA_WIDTH'(4'hF);
        viol = '0;
        viol[ERR_WB]     = (ack_i && !(cyc_o && stb_o)) || (stb_o && !cyc_o) ||
                           (ack_i && ack_q && stb_o && stb_q);
        viol[ERR_STABLE] = wait_q && stb_o &&
                           (adr_o != adr_q || we_o != we_q || (we_o && dat_o != dat_q));
        viol[ERR_REG]    = acc && ((we_o && is_fsmr) || (!we_o && is_csr && |csr_rsvd));
        viol[ERR_IRQ]    = irq_i && (!ie_q || cmdr_rd_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flags     <= '0;
            err_count <= '0;
            ack_q     <= 1'b0;
            stb_q     <= 1'b0;
            wait_q    <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            ie_q      <= 1'b0;
            cmdr_rd_q <= 1'b0;
        end else begin
            flags <= flags | viol;
            if ((|viol || |i2c_viol) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            ack_q     <= ack_i;
            stb_q     <= stb_o;
            wait_q    <= stb_o && !ack_i;
            we_q      <= we_o;
            adr_q     <= adr_o;
            dat_q     <= dat_o;
            cmdr_rd_q <= acc && !we_o && is_cmdr;
            if (acc && we_o && is_csr)
                ie_q <= dat_o[CSR_IE];
        end
    end

    assign err_wb     = flags[ERR_WB];
    assign err_stable = flags[ERR_STABLE];
    assign err_reg    = flags[ERR_REG];
    assign err_irq    = flags[ERR_IRQ];
    assign err_any    = |flags || |err_i2c;
endmodule

// File: tb/tb_i2cmb_protocol_checker.sv
// tb_i2cmb_protocol_checker: directed plan plus randomized traffic checked against a rule-level model
module tb_i2cmb_protocol_checker;
    localparam int NB = 2;

    logic clk = 1'b0, rst = 1'b0, irq_i = 1'b0;
    logic cyc_o = 1'b0, stb_o = 1'b0, we_o = 1'b0, ack_i = 1'b0;
    logic [1:0] adr_o = '0;
    logic [7:0] dat_o = '0, dat_i = '0;
    logic [NB-1:0] scl_i = '1, sda_i = '1;
    logic err_wb, err_stable, err_reg, err_irq, err_any;
    logic [NB-1:0] err_i2c, i2c_busy;
    logic [15:0] err_count;

    int total = 0, bad = 0;

    // model state: sticky flags, shadow IE, previous request and pin history (index 0 = newest)
    logic m_wb, m_st, m_reg, m_irq, m_ie, m_cmdr_rd;
    logic [NB-1:0] m_i2c, m_busy;
    int m_cnt;
    logic p_stb, p_ack, p_we;
    logic [1:0] p_adr;
    logic [7:0] p_wd;
    logic [NB-1:0] scl_h[3], sda_h[3];

    i2cmb_protocol_checker #(.NUM_I2C_BUSSES(NB), .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .irq_i(irq_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .ack_i(ack_i), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .scl_i(scl_i), .sda_i(sda_i),
        .err_wb(err_wb), .err_stable(err_stable), .err_reg(err_reg), .err_irq(err_irq),
        .err_i2c(err_i2c), .err_any(err_any), .err_count(err_count), .i2c_busy(i2c_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic v_wb, v_st, v_reg, v_irq, any, acked;
        @(posedge clk);
        if (!rst) begin
            {m_wb, m_st, m_reg, m_irq, m_ie, m_cmdr_rd} = '0;
            m_i2c = '0;
            m_busy = '0;
            m_cnt = 0;
            {p_stb, p_ack, p_we, p_adr, p_wd} = '0;
            for (int k = 0; k < 3; k++) begin
                scl_h[k] = '1;
                sda_h[k] = '1;
            end
        end else begin
            acked = cyc_o && stb_o && ack_i;
            v_wb  = (ack_i && !(cyc_o && stb_o)) || (stb_o && !cyc_o) || (ack_i && p_ack && stb_o && p_stb);
            v_st  = p_stb && !p_ack && stb_o && (adr_o != p_adr || we_o != p_we || (we_o && dat_o != p_wd));
            v_reg = acked && ((we_o && adr_o == 2'd3) || (!we_o && adr_o == 2'd0 && dat_i[3:0] != 4'h0));
            v_irq = irq_i && (!m_ie || m_cmdr_rd);
            any = v_wb || v_st || v_reg || v_irq;
            for (int b = 0; b < NB; b++) begin
                if (scl_h[1][b] && scl_h[2][b]) begin
                    if (sda_h[2][b] && !sda_h[1][b]) m_busy[b] = 1'b1;
                    else if (!sda_h[2][b] && sda_h[1][b]) begin
                        if (!m_busy[b]) begin
                            m_i2c[b] = 1'b1;
                            any = 1'b1;
                        end
                        m_busy[b] = 1'b0;
                    end
                end
            end
            m_wb |= v_wb;
            m_st |= v_st;
            m_reg |= v_reg;
            m_irq |= v_irq;
            if (any && m_cnt < 65535) m_cnt++;
            if (acked && we_o && adr_o == 2'd0) m_ie = dat_o[6];
            m_cmdr_rd = acked && !we_o && adr_o == 2'd2;
            {p_stb, p_ack, p_we, p_adr, p_wd} = {stb_o, ack_i, we_o, adr_o, dat_o};
            scl_h[2] = scl_h[1]; scl_h[1] = scl_h[0]; scl_h[0] = scl_i;
            sda_h[2] = sda_h[1]; sda_h[1] = sda_h[0]; sda_h[0] = sda_i;
        end
        #1;
        chk("err_wb", 32'(err_wb), 32'(m_wb));
        chk("err_stable", 32'(err_stable), 32'(m_st));
        chk("err_reg", 32'(err_reg), 32'(m_reg));
        chk("err_irq", 32'(err_irq), 32'(m_irq));
        chk("err_i2c", 32'(err_i2c), 32'(m_i2c));
        chk("i2c_busy", 32'(i2c_busy), 32'(m_busy));
        chk("err_any", 32'(err_any), 32'(m_wb | m_st | m_reg | m_irq | (|m_i2c)));
        chk("err_count", 32'(err_count), 32'(m_cnt));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic wb(input logic w, input logic [1:0] a, input logic [7:0] wd, input logic [7:0] rd);
        {cyc_o, stb_o, we_o, adr_o, dat_o} = {1'b1, 1'b1, w, a, wd};
        tick();
        ack_i = 1'b1;
        dat_i = rd;
        tick();
        {cyc_o, stb_o, ack_i, dat_i} = '0;
        tick();
    endtask

    initial begin
        do_reset();
        chk("reset_any", 32'(err_any), 32'd0);
        chk("reset_count", 32'(err_count), 32'd0);
        chk("reset_busy", 32'(i2c_busy), 32'd0);

        wb(1'b1, 2'd0, 8'hC0, 8'h00);
        wb(1'b0, 2'd2, 8'h00, 8'h00);
        tick();
        chk("legal_any", 32'(err_any), 32'd0);
        chk("legal_count", 32'(err_count), 32'd0);

        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("ackcyc_wb", 32'(err_wb), 32'd1);
        chk("ackcyc_count", 32'(err_count), 32'd1);
        repeat (3) tick();
        chk("ackcyc_sticky", 32'(err_wb), 32'd1);
        do_reset();
        chk("ackcyc_cleared", 32'(err_wb), 32'd0);

        {cyc_o, stb_o, we_o, adr_o} = {1'b1, 1'b1, 1'b0, 2'd1};
        tick();
        adr_o = 2'd2;
        tick();
        chk("stable_flag", 32'(err_stable), 32'd1);
        ack_i = 1'b1;
        tick();
        {cyc_o, stb_o, ack_i} = '0;
        tick();
        do_reset();

        wb(1'b1, 2'd3, 8'h55, 8'h00);
        chk("fsmr_write", 32'(err_reg), 32'd1);
        do_reset();

        wb(1'b1, 2'd0, 8'hC0, 8'h00);
        wb(1'b1, 2'd0, 8'h80, 8'h00);
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        chk("irq_ie0", 32'(err_irq), 32'd1);
        do_reset();

        ack_i = 1'b1;
        irq_i = 1'b1;
        tick();
        {ack_i, irq_i} = '0;
        chk("simul_flags", 32'({err_wb, err_irq}), 32'b11);
        chk("simul_count", 32'(err_count), 32'd1);
        do_reset();

        sda_i[0] = 1'b0;
        tick();
        tick();
        chk("start_early", 32'(i2c_busy), 32'd0);
        tick();
        chk("start_busy", 32'(i2c_busy), 32'd1);
        sda_i[0] = 1'b1;
        repeat (3) tick();
        chk("stop_idle", 32'(i2c_busy), 32'd0);
        scl_i[0] = 1'b0;
        tick();
        sda_i[0] = 1'b0;
        tick();
        scl_i[0] = 1'b1;
        tick();
        sda_i[0] = 1'b1;
        repeat (3) tick();
        chk("stop_err", 32'(err_i2c), 32'd1);
        chk("stop_err_count", 32'(err_count), 32'd1);
        do_reset();

        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (!(stb_o && !ack_i) || $urandom_range(0, 29) == 0) begin
                adr_o = 2'($urandom);
                we_o  = 1'($urandom);
                dat_o = 8'($urandom);
            end
            cyc_o = ($urandom_range(0, 3) != 0);
            stb_o = cyc_o ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            ack_i = (cyc_o && stb_o && $urandom_range(0, 1) == 1) || ($urandom_range(0, 39) == 0);
            dat_i = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {4'($urandom_range(0, 15)), 4'h0};
            irq_i = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 3) == 0) scl_i[b] = ~scl_i[b];
                if ($urandom_range(0, 3) == 0) sda_i[b] = ~sda_i[b];
            end
            tick();
        end

        rst = 1'b1;
        {cyc_o, stb_o, irq_i} = '0;
        scl_i = '1;
        sda_i = '1;
        do_reset();
        ack_i = 1'b1;
        repeat (65540) tick();
        ack_i = 1'b0;
        chk("count_saturated", 32'(err_count), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
